// File: rtl/fifo_to_elink_tx.sv
// Transmit framer: pops 76-bit CAN frames from the TX FIFO and emits them as
// SOP / 10 data bytes (MSB first) / EOP symbols, one per encoder byte_rdy strobe.
module fifo_to_elink_tx #(
    parameter int DATA_W   = 76,
    parameter int IDLE_GAP = 2
) (
    input  logic              bitCLKx4,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              byte_rdy,
    output logic [7:0]        tx_data_8bit,
    output logic [1:0]        tx_delimiter,
    output logic              tx_busy,
    output logic [15:0]       frame_cnt
);

    localparam int          NBYTES      = 10;
    localparam int          FRAME_BITS  = NBYTES * 8;
    localparam int          PAD_W       = FRAME_BITS - DATA_W;
    localparam int          FETCH_SLOTS = 2;
    localparam logic [3:0]  LAST_BYTE   = 4'(NBYTES - 1);
    localparam logic [3:0]  GAP_MAX     = 4'd15;

    localparam logic [1:0]  DLM_DATA = 2'b00;
    localparam logic [1:0]  DLM_EOP  = 2'b01;
    localparam logic [1:0]  DLM_SOP  = 2'b10;
    localparam logic [1:0]  DLM_IDLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SOP,
        S_DATA,
        S_EOP
    } state_t;

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [3:0]              byte_idx_q, byte_idx_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    fifo_rd_en_q, fifo_rd_en_d;
    logic                    tx_busy_q, tx_busy_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic [1:0]              tx_delim_q, tx_delim_d;
    logic [FRAME_BITS-1:0]   frame_shifted;
    logic                    gap_ok;

    // FETCH and LOAD each present an idle slot, so they are credited toward the gap.
    assign gap_ok        = (int'(gap_cnt_q) + FETCH_SLOTS) >= IDLE_GAP;
    assign frame_shifted = frame_d << {byte_idx_d, 3'b000};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        frame_d     = frame_q;
        byte_idx_d  = byte_idx_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;

        if ((state_q == S_IDLE || state_q == S_FETCH || state_q == S_LOAD)
            && byte_rdy && gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
        end

        unique case (state_q)
            S_IDLE:  if (enable && !fifo_empty && gap_ok) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                frame_d    = {{PAD_W{1'b0}}, fifo_dout};
                byte_idx_d = 4'd0;
                state_d    = S_SOP;
            end
            S_SOP:   if (byte_rdy) state_d = S_DATA;
            S_DATA: begin
                if (byte_rdy) begin
                    byte_idx_d = byte_idx_q + 4'd1;
                    if (byte_idx_q == LAST_BYTE) state_d = S_EOP;
                end
            end
            S_EOP: begin
                if (byte_rdy) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_cnt_d   = 4'd0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned.
        fifo_rd_en_d = (state_d == S_FETCH);
        tx_busy_d    = (state_d != S_IDLE);
        tx_data_d    = 8'h00;
        tx_delim_d   = DLM_IDLE;
        case (state_d)
            S_SOP:  tx_delim_d = DLM_SOP;
            S_DATA: begin
                tx_delim_d = DLM_DATA;
                tx_data_d  = frame_shifted[FRAME_BITS-1 -: 8];
            end
            S_EOP:  tx_delim_d = DLM_EOP;
            default: tx_delim_d = DLM_IDLE;
        endcase
    end

    always_ff @(posedge bitCLKx4 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            frame_q      <= '0;
            byte_idx_q   <= 4'd0;
            gap_cnt_q    <= GAP_MAX;
            frame_cnt_q  <= 16'd0;
            fifo_rd_en_q <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_delim_q   <= DLM_IDLE;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            byte_idx_q   <= byte_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            tx_busy_q    <= tx_busy_d;
            tx_data_q    <= tx_data_d;
            tx_delim_q   <= tx_delim_d;
        end
    end

    assign fifo_rd_en   = fifo_rd_en_q;
    assign tx_busy      = tx_busy_q;
    assign tx_data_8bit = tx_data_q;
    assign tx_delimiter = tx_delim_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_fifo_to_elink_tx.sv
// Self-checking bench for fifo_to_elink_tx: FIFO model, symbol scoreboard built
// from the framing rules, and directed scenarios with randomized payloads/strobes.
module tb_fifo_to_elink_tx;

    localparam int IDLE_GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [75:0] fifo_dout = '0;
    logic        byte_rdy;
    logic [7:0]  tx_data;
    logic [1:0]  tx_delim;
    logic        tx_busy;
    logic [15:0] frame_cnt;

    fifo_to_elink_tx #(.DATA_W(76), .IDLE_GAP(IDLE_GAP)) dut (
        .bitCLKx4     (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .byte_rdy     (byte_rdy),
        .tx_data_8bit (tx_data),
        .tx_delimiter (tx_delim),
        .tx_busy      (tx_busy),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    // Simple FIFO: data appears the cycle after a pop.
    logic [75:0] fifo_mem [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && wr_ptr != rd_ptr) begin
            fifo_dout <= fifo_mem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          rd_pulses = 0;
    int          rd_cycle = 0;
    int          data_seen = 0;
    int          idles_since_eop = 100;
    int          rdy_mode = 0;
    bit          gap_check_on = 1'b1;
    bit          in_frame = 1'b0;
    bit          prev_rdy = 1'b1;
    logic [9:0]  prev_sym = 10'h300;
    logic [15:0] exp_cnt = 16'd0;
    logic [9:0]  exp_q [$];
    int          sop_cycles [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Expected symbol stream for one frame: SOP, bytes MSB first over {4'b0, frame}, EOP.
    task automatic push_frame(input logic [75:0] f);
        logic [79:0] ext;
        fifo_mem[wr_ptr % 32] = f;
        wr_ptr++;
        ext = {4'b0000, f};
        exp_q.push_back({2'b10, 8'h00});
        for (int k = 0; k < 10; k++) exp_q.push_back({2'b00, ext[79 - 8*k -: 8]});
        exp_q.push_back({2'b01, 8'h00});
    endtask

    task automatic push_random_frame();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        push_frame(r[75:0]);
    endtask

    // One clock: observe at the falling edge, then drive byte_rdy just after the rising edge.
    task automatic tick();
        logic [9:0] sym;
        logic [9:0] e;
        @(negedge clk);
        cycle++;
        sym = {tx_delim, tx_data};
        if (fifo_rd_en) begin
            check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
            rd_pulses++;
            rd_cycle = cycle;
            in_frame = 1'b1;
        end
        check("tx_busy", 32'(tx_busy), 32'(in_frame));
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        if (tx_delim == 2'b11) check("idle_data", 32'(tx_data), 32'd0);
        if (prev_sym[9:8] != 2'b11 && !prev_rdy && !rst) check("symbol_hold", 32'(sym), 32'(prev_sym));
        if (tx_delim == 2'b10 && prev_sym[9:8] != 2'b10) begin
            sop_cycles.push_back(cycle);
            check("rd_en_to_sop", 32'(cycle - rd_cycle), 32'd2);
        end
        if (byte_rdy && !rst) begin
            if (tx_delim == 2'b11) begin
                idles_since_eop++;
            end else begin
                if (exp_q.size() == 0) begin
                    check("unexpected_symbol", 32'(sym), 32'h3ff);
                end else begin
                    e = exp_q.pop_front();
                    check("symbol", 32'(sym), 32'(e));
                end
                if (tx_delim == 2'b10 && gap_check_on)
                    check("idle_gap", 32'(idles_since_eop >= IDLE_GAP), 32'd1);
                if (tx_delim == 2'b00) data_seen++;
                if (tx_delim == 2'b01) begin
                    exp_cnt++;
                    in_frame = 1'b0;
                    idles_since_eop = 0;
                    data_seen = 0;
                end
            end
        end
        prev_sym = sym;
        prev_rdy = byte_rdy;
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       byte_rdy = 1'b1;
            1:       byte_rdy = (cycle % 5 == 0);
            2:       byte_rdy = 1'($urandom % 2);
            default: byte_rdy = ~byte_rdy;
        endcase
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_data_byte(input int idx, input int budget);
        int n;
        n = 0;
        while (!(tx_delim == 2'b00 && data_seen == idx) && n < budget) begin
            tick();
            n++;
        end
        check("reach_data_byte", 32'(data_seen), 32'(idx));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int base;
        rst = 1'b1;
        enable = 1'b1;
        byte_rdy = 1'b1;
        #12;
        check("reset_delim", 32'(tx_delim), 32'h3);
        check("reset_data", 32'(tx_data), 32'h0);
        check("reset_rd_en", 32'(fifo_rd_en), 32'h0);
        check("reset_busy", 32'(tx_busy), 32'h0);
        check("reset_cnt", 32'(frame_cnt), 32'h0);
        rst = 1'b0;
        repeat (3) tick();

        // Single known frame, byte_rdy every cycle.
        push_frame(76'hA_BCDE_F012_3456_789A);
        drain(60);
        check("single_rd_pulses", 32'(rd_pulses), 32'd1);
        check("single_frame_cnt", 32'(frame_cnt), 32'd1);

        // Two back-to-back frames: minimum period and idle gap.
        base = sop_cycles.size();
        push_random_frame();
        push_random_frame();
        drain(80);
        check("sop_count", 32'(sop_cycles.size() - base), 32'd2);
        if (sop_cycles.size() >= base + 2)
            check("sop_period", 32'(sop_cycles[base+1] - sop_cycles[base]), 32'd15);
        check("two_frame_cnt", 32'(frame_cnt), 32'd3);

        // byte_rdy strobed 1-in-5: symbols held and accepted exactly once.
        rdy_mode = 1;
        gap_check_on = 1'b0;
        push_random_frame();
        push_random_frame();
        drain(400);
        check("strobe_frame_cnt", 32'(frame_cnt), 32'd5);

        // enable dropped during data byte 4.
        rdy_mode = 0;
        repeat (2) tick();
        gap_check_on = 1'b1;
        rd0 = rd_pulses;
        push_random_frame();
        push_random_frame();
        wait_data_byte(4, 60);
        enable = 1'b0;
        begin
            int n;
            n = 0;
            while (exp_q.size() > 12 && n < 60) begin
                tick();
                n++;
            end
        end
        repeat (30) tick();
        check("disabled_rd_pulses", 32'(rd_pulses - rd0), 32'd1);
        check("disabled_idle", 32'(tx_delim), 32'h3);
        check("disabled_busy", 32'(tx_busy), 32'h0);
        enable = 1'b1;
        drain(60);
        check("enabled_rd_pulses", 32'(rd_pulses - rd0), 32'd2);

        // Reset during data byte 6 drops the frame.
        push_random_frame();
        push_random_frame();
        wait_data_byte(6, 60);
        rst = 1'b1;
        #1;
        check("midrst_delim", 32'(tx_delim), 32'h3);
        check("midrst_data", 32'(tx_data), 32'h0);
        check("midrst_cnt", 32'(frame_cnt), 32'h0);
        check("midrst_busy", 32'(tx_busy), 32'h0);
        check("midrst_rd_en", 32'(fifo_rd_en), 32'h0);
        while (exp_q.size() != 0 && exp_q[0][9:8] != 2'b01) void'(exp_q.pop_front());
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_cnt = 16'd0;
        in_frame = 1'b0;
        data_seen = 0;
        prev_sym = 10'h300;
        idles_since_eop = 100;
        repeat (2) tick();
        rst = 1'b0;
        drain(60);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        // Random byte_rdy with random payloads.
        rdy_mode = 2;
        gap_check_on = 1'b0;
        repeat (3) push_random_frame();
        drain(300);
        check("random_frame_cnt", 32'(frame_cnt), 32'd4);

        // Empty FIFO with toggling byte_rdy.
        rdy_mode = 3;
        rd0 = rd_pulses;
        repeat (100) begin
            tick();
            check("empty_rd_en", 32'(fifo_rd_en), 32'd0);
            check("empty_delim", 32'(tx_delim), 32'h3);
        end
        check("empty_rd_pulses", 32'(rd_pulses - rd0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
